// File: rtl/grid_step_generator.sv
// Raster-order grid walker: emits one write strobe per cell of a GRID_COLS x GRID_ROWS grid,
// stepped by a debounced push-button or by an internal auto-step timer.
module grid_step_generator #(
    parameter int X_W          = 4,
    parameter int Y_W          = 4,
    parameter int VAL_W        = 2,
    parameter int GRID_COLS    = 11,
    parameter int GRID_ROWS    = 11,
    parameter int VAL_CONST    = 1,
    parameter int DEBOUNCE_CYC = 16,
    parameter int TIMER_W      = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               click,
    input  logic               auto_mode,
    input  logic [TIMER_W-1:0] period,
    input  logic [1:0]         val_mode,
    input  logic [VAL_W-1:0]   value_in,
    input  logic               loop,
    input  logic               restart,
    output logic [X_W-1:0]     X_COORD,
    output logic [Y_W-1:0]     Y_COORD,
    output logic [VAL_W-1:0]   VALUE,
    output logic               ENABLE,
    output logic               frame_done
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STROBE = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(GRID_COLS - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(GRID_ROWS - 1);

    logic [1:0]         sync_r;
    logic               deb_r;
    logic [CNT_W-1:0]   deb_cnt_r;
    logic               click_fall_r;

    logic [TIMER_W-1:0] timer_r;
    logic [TIMER_W-1:0] period_q_r;
    logic               auto_q_r;
    logic [TIMER_W-1:0] reload_s;
    logic               timer_hold_s;
    logic               timer_step_s;
    logic               step_req_s;

    state_t             state_r;
    logic [X_W-1:0]     x_r;
    logic [Y_W-1:0]     y_r;
    logic [VAL_W-1:0]   step_cnt_r;
    logic               enable_r;
    logic               frame_done_r;
    logic               last_cell_s;

    // Click synchronizer and debouncer; a debounced press yields a one-cycle pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r       <= 2'b11;
            deb_r        <= 1'b1;
            deb_cnt_r    <= {CNT_W{1'b0}};
            click_fall_r <= 1'b0;
        end else begin
            sync_r       <= {sync_r[0], click};
            click_fall_r <= 1'b0;
            if (sync_r[1] != deb_r) begin
                if (deb_cnt_r == DEB_LAST) begin
                    deb_r        <= sync_r[1];
                    deb_cnt_r    <= {CNT_W{1'b0}};
                    // deb_r is still 1 here only when the new level is a press
                    click_fall_r <= deb_r;
                end else begin
                    deb_cnt_r <= deb_cnt_r + CNT_W'(1);
                end
            end else begin
                deb_cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    // Timer reload value, clamped so the period is never shorter than one strobe plus one idle cycle
    always_comb begin
        if (period < TIMER_W'(2)) begin
            reload_s = TIMER_W'(1);
        end else begin
            reload_s = period - TIMER_W'(1);
        end
    end

    // A mode or period change forces a reload instead of letting a stale count expire
    assign timer_hold_s = ~auto_mode | (period != period_q_r) | (auto_mode != auto_q_r);
    assign timer_step_s = ~timer_hold_s & (timer_r == {TIMER_W{1'b0}});
    assign step_req_s   = auto_mode ? timer_step_s : click_fall_r;
    assign last_cell_s  = (x_r == X_LAST) & (y_r == Y_LAST);

    // Auto-step down-counter
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r    <= reload_s;
            period_q_r <= period;
            auto_q_r   <= auto_mode;
        end else begin
            period_q_r <= period;
            auto_q_r   <= auto_mode;
            if (restart || timer_hold_s || (timer_r == {TIMER_W{1'b0}})) begin
                timer_r <= reload_s;
            end else begin
                timer_r <= timer_r - TIMER_W'(1);
            end
        end
    end

    // Walk FSM: coordinates, step counter and registered strobe outputs
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state_r      <= ST_RUN;
            x_r          <= {X_W{1'b0}};
            y_r          <= {Y_W{1'b0}};
            step_cnt_r   <= {VAL_W{1'b0}};
            enable_r     <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            enable_r     <= 1'b0;
            frame_done_r <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    if (step_req_s) begin
                        state_r      <= ST_STROBE;
                        enable_r     <= 1'b1;
                        frame_done_r <= last_cell_s;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_STROBE: begin
                    step_cnt_r <= step_cnt_r + VAL_W'(1);
                    if (last_cell_s) begin
                        x_r     <= {X_W{1'b0}};
                        y_r     <= {Y_W{1'b0}};
                        state_r <= loop ? ST_RUN : ST_HALT;
                    end else if (x_r == X_LAST) begin
                        x_r     <= {X_W{1'b0}};
                        y_r     <= y_r + Y_W'(1);
                        state_r <= ST_RUN;
                    end else begin
                        x_r     <= x_r + X_W'(1);
                        state_r <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

    // Cell value selection from registered state
    always_comb begin
        case (val_mode)
            2'd0:    VALUE = VAL_W'(VAL_CONST);
            2'd1:    VALUE = VAL_W'(x_r[0] ^ y_r[0]);
            2'd2:    VALUE = step_cnt_r;
            2'd3:    VALUE = value_in;
            default: VALUE = value_in;
        endcase
    end

    assign X_COORD    = x_r;
    assign Y_COORD    = y_r;
    assign ENABLE     = enable_r;
    assign frame_done = frame_done_r;

endmodule
